// File: rtl/main_mem_ctrl.sv
// Single-port main memory model shared by icache and dcache: round-robin grant,
// one outstanding request, fixed response latency, preload port usable at any time.
module main_mem_ctrl #(
  parameter int BLOCK_DATA_WIDTH = 64,
  parameter int BLOCK_ADDR_WIDTH = 29,
  parameter int MEM_N_BLOCKS     = 1024,
  parameter int LATENCY          = 4
) (
  input  logic                        clk,
  input  logic                        rst_aL,
  input  logic                        init_valid,
  input  logic [BLOCK_ADDR_WIDTH-1:0] init_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] init_block_data,
  input  logic                        icache_req_valid,
  input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
  output logic                        icache_req_ready,
  output logic                        icache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data,
  input  logic                        dcache_req_valid,
  input  logic                        dcache_req_type,
  input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data,
  output logic                        dcache_req_ready,
  output logic                        dcache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data
);

  // state | meaning
  // IDLE  | no request outstanding, may grant a port
  // BUSY  | counting down to the response of the latched request
  typedef enum logic {IDLE, BUSY} state_t;
  typedef logic [BLOCK_DATA_WIDTH-1:0] block_data_t;
  typedef logic [BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;

  localparam int IDX_W = (MEM_N_BLOCKS > 1) ? $clog2(MEM_N_BLOCKS) : 1;
  localparam main_mem_block_addr_t N_BLK  = BLOCK_ADDR_WIDTH'(MEM_N_BLOCKS);
  localparam logic [7:0]           LAT_M1 = 8'(LATENCY - 1);

  state_t               state_q;
  logic [7:0]           cnt_q;
  logic                 owner_dc_q;
  logic                 last_dc_q;
  logic                 wr_q;
  main_mem_block_addr_t addr_q;
  block_data_t          wdata_q;
  block_data_t          mem_q [MEM_N_BLOCKS];

  logic             idle_free;
  logic             ic_acc;
  logic             dc_acc;
  logic             resp_fire;
  logic [IDX_W-1:0] busy_idx;
  logic [IDX_W-1:0] init_idx;
  block_data_t      resp_data;

  assign busy_idx = IDX_W'(addr_q % N_BLK);
  assign init_idx = IDX_W'(init_block_addr % N_BLK);

  // Tie goes to whichever port was not granted last.
  assign idle_free        = (state_q == IDLE) && !init_valid;
  assign icache_req_ready = idle_free && icache_req_valid && (!dcache_req_valid || last_dc_q);
  assign dcache_req_ready = idle_free && dcache_req_valid && (!icache_req_valid || !last_dc_q);
  assign ic_acc           = icache_req_valid && icache_req_ready;
  assign dc_acc           = dcache_req_valid && dcache_req_ready;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_dc_q <= 1'b0;
      last_dc_q  <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ic_acc || dc_acc) begin
            state_q    <= BUSY;
            cnt_q      <= LAT_M1;
            owner_dc_q <= dc_acc;
            last_dc_q  <= dc_acc;
            wr_q       <= dc_acc && dcache_req_type;
            addr_q     <= dc_acc ? dcache_req_block_addr : icache_req_block_addr;
            wdata_q    <= dcache_req_block_data;
          end
        end
        BUSY: begin
          if (cnt_q == 8'd0) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 8'd1;
        end
      endcase
    end
  end

  assign resp_fire = (state_q == BUSY) && (cnt_q == 8'd0);

  // Storage is never reset; a preload on the same edge as a write-back wins.
  always_ff @(posedge clk) begin
    if (resp_fire && wr_q) mem_q[busy_idx] <= wdata_q;
    if (init_valid)        mem_q[init_idx] <= init_block_data;
  end

  assign resp_data              = wr_q ? wdata_q : mem_q[busy_idx];
  assign icache_resp_valid      = resp_fire && !owner_dc_q;
  assign dcache_resp_valid      = resp_fire && owner_dc_q;
  assign icache_resp_block_data = icache_resp_valid ? resp_data : '0;
  assign dcache_resp_block_data = dcache_resp_valid ? resp_data : '0;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: directed scenarios plus randomized
// contention checked against a transaction-level reference model.
module tb_main_mem_ctrl;
  localparam int LAT = 4;

  logic        clk;
  logic        rst_aL;
  logic        init_valid;
  logic [28:0] init_block_addr;
  logic [63:0] init_block_data;
  logic        icache_req_valid;
  logic [28:0] icache_req_block_addr;
  logic        icache_req_ready;
  logic        icache_resp_valid;
  logic [63:0] icache_resp_block_data;
  logic        dcache_req_valid;
  logic        dcache_req_type;
  logic [28:0] dcache_req_block_addr;
  logic [63:0] dcache_req_block_data;
  logic        dcache_req_ready;
  logic        dcache_resp_valid;
  logic [63:0] dcache_resp_block_data;

  int vectors = 0;
  int miscompares = 0;

  main_mem_ctrl #(
    .BLOCK_DATA_WIDTH(64), .BLOCK_ADDR_WIDTH(29), .MEM_N_BLOCKS(1024), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_aL(rst_aL),
    .init_valid(init_valid), .init_block_addr(init_block_addr), .init_block_data(init_block_data),
    .icache_req_valid(icache_req_valid), .icache_req_block_addr(icache_req_block_addr),
    .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
    .icache_resp_block_data(icache_resp_block_data),
    .dcache_req_valid(dcache_req_valid), .dcache_req_type(dcache_req_type),
    .dcache_req_block_addr(dcache_req_block_addr), .dcache_req_block_data(dcache_req_block_data),
    .dcache_req_ready(dcache_req_ready), .dcache_resp_valid(dcache_resp_valid),
    .dcache_resp_block_data(dcache_resp_block_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    init_valid = 1'b0; init_block_addr = '0; init_block_data = '0;
    icache_req_valid = 1'b0; icache_req_block_addr = '0;
    dcache_req_valid = 1'b0; dcache_req_type = 1'b0;
    dcache_req_block_addr = '0; dcache_req_block_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_aL = 1'b0;
    repeat (2) tick();
    rst_aL = 1'b1;
  endtask

  task automatic preload(input logic [28:0] a, input logic [63:0] d);
    init_valid = 1'b1; init_block_addr = a; init_block_data = d;
    tick();
    init_valid = 1'b0;
  endtask

  // Issues one request and observes the following window; reports what it saw.
  task automatic txn(input bit is_dc, input bit wr, input logic [28:0] a, input logic [63:0] d,
                     output int waited, output int lat, output logic [63:0] rd,
                     output int n_own, output int n_other);
    bit own, other;
    waited = 0; lat = -1; rd = '0; n_own = 0; n_other = 0;
    if (is_dc) begin
      dcache_req_valid = 1'b1; dcache_req_type = wr;
      dcache_req_block_addr = a; dcache_req_block_data = d;
    end else begin
      icache_req_valid = 1'b1; icache_req_block_addr = a;
    end
    #1;
    while (!(is_dc ? dcache_req_ready : icache_req_ready) && waited < 20) begin
      tick(); #1; waited++;
    end
    tick();
    dcache_req_valid = 1'b0; icache_req_valid = 1'b0;
    for (int k = 1; k <= LAT + 4; k++) begin
      #1;
      own   = is_dc ? dcache_resp_valid : icache_resp_valid;
      other = is_dc ? icache_resp_valid : dcache_resp_valid;
      if (own) begin
        n_own++;
        if (lat < 0) begin
          lat = k;
          rd  = is_dc ? dcache_resp_block_data : icache_resp_block_data;
        end
      end
      if (other) n_other++;
      tick();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_aL = 1'b0;
    #3;
    vectors++;
    if (icache_resp_valid !== 1'b0 || dcache_resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_resp_valid got ic=%b dc=%b exp 0 0", icache_resp_valid, dcache_resp_valid);
    end
    vectors++;
    if (icache_resp_block_data !== 64'h0 || dcache_resp_block_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_resp_data got ic=%h dc=%h exp 0 0", icache_resp_block_data, dcache_resp_block_data);
    end
    repeat (2) tick();
    rst_aL = 1'b1;
    #1;
    vectors++;
    if (icache_req_ready !== 1'b0 || dcache_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_ready got ic=%b dc=%b exp 0 0", icache_req_ready, dcache_req_ready);
    end
  endtask

  task automatic test_round_robin();
    preload(29'h1, 64'h1111_0000_0000_0001);
    preload(29'h2, 64'h2222_0000_0000_0002);
    icache_req_valid = 1'b1; icache_req_block_addr = 29'h1;
    dcache_req_valid = 1'b1; dcache_req_type = 1'b0; dcache_req_block_addr = 29'h2;
    #1;
    vectors++;
    if (dcache_req_ready !== 1'b1 || icache_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_first_tie got dc_rdy=%b ic_rdy=%b exp 1 0", dcache_req_ready, icache_req_ready);
    end
    tick();
    dcache_req_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      #1;
      vectors++;
      if (icache_req_ready !== 1'b0 || dcache_resp_valid !== (k == LAT) || icache_resp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_dc_window k=%0d got ic_rdy=%b dc_rv=%b ic_rv=%b exp 0 %b 0",
                 k, icache_req_ready, dcache_resp_valid, icache_resp_valid, (k == LAT));
      end
      if (k == LAT) begin
        vectors++;
        if (dcache_resp_block_data !== 64'h2222_0000_0000_0002) begin
          miscompares++;
          $display("FAIL rr_dc_data got %h exp %h", dcache_resp_block_data, 64'h2222_0000_0000_0002);
        end
      end
      tick();
    end
    #1;
    vectors++;
    if (icache_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rr_ic_second got ic_rdy=%b exp 1", icache_req_ready);
    end
    tick();
    icache_req_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      #1;
      vectors++;
      if (icache_resp_valid !== (k == LAT) || dcache_resp_valid !== 1'b0 ||
          (k == LAT && icache_resp_block_data !== 64'h1111_0000_0000_0001)) begin
        miscompares++;
        $display("FAIL rr_ic_window k=%0d got ic_rv=%b dc_rv=%b data=%h exp %b 0 %h", k,
                 icache_resp_valid, dcache_resp_valid, icache_resp_block_data, (k == LAT),
                 64'h1111_0000_0000_0001);
      end
      tick();
    end
  endtask

  task automatic test_preload_read();
    int w, l, no, nx;
    logic [63:0] rd;
    preload(29'h10, 64'hDEADBEEF_00000001);
    txn(1'b0, 1'b0, 29'h10, 64'h0, w, l, rd, no, nx);
    vectors++;
    if (l !== LAT || rd !== 64'hDEADBEEF_00000001 || no !== 1 || nx !== 0) begin
      miscompares++;
      $display("FAIL preload_read got lat=%0d data=%h pulses=%0d other=%0d exp %0d %h 1 0",
               l, rd, no, nx, LAT, 64'hDEADBEEF_00000001);
    end
  endtask

  task automatic test_write_read();
    int w, l, no, nx;
    logic [63:0] rd;
    txn(1'b1, 1'b1, 29'h20, 64'hA5A5, w, l, rd, no, nx);
    vectors++;
    if (l !== LAT || rd !== 64'hA5A5 || no !== 1 || nx !== 0) begin
      miscompares++;
      $display("FAIL write_ack got lat=%0d data=%h pulses=%0d other=%0d exp %0d a5a5 1 0", l, rd, no, nx, LAT);
    end
    txn(1'b1, 1'b0, 29'h20, 64'h0, w, l, rd, no, nx);
    vectors++;
    if (l !== LAT || rd !== 64'hA5A5 || no !== 1) begin
      miscompares++;
      $display("FAIL write_readback got lat=%0d data=%h pulses=%0d exp %0d a5a5 1", l, rd, no, LAT);
    end
  endtask

  task automatic test_alias();
    int w, l, no, nx;
    logic [63:0] rd;
    txn(1'b1, 1'b1, 29'h400, 64'h7, w, l, rd, no, nx);
    txn(1'b1, 1'b0, 29'h0, 64'h0, w, l, rd, no, nx);
    vectors++;
    if (rd !== 64'h7 || l !== LAT) begin
      miscompares++;
      $display("FAIL alias_dc got data=%h lat=%0d exp 7 %0d", rd, l, LAT);
    end
    txn(1'b0, 1'b0, 29'h800, 64'h0, w, l, rd, no, nx);
    vectors++;
    if (rd !== 64'h7 || l !== LAT) begin
      miscompares++;
      $display("FAIL alias_ic got data=%h lat=%0d exp 7 %0d", rd, l, LAT);
    end
  endtask

  task automatic test_reset_mid_busy();
    int w, l, no, nx;
    int seen;
    logic [63:0] rd;
    preload(29'h30, 64'h1234);
    dcache_req_valid = 1'b1; dcache_req_type = 1'b1;
    dcache_req_block_addr = 29'h30; dcache_req_block_data = 64'h9;
    #1;
    vectors++;
    if (dcache_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_accept got dc_rdy=%b exp 1", dcache_req_ready);
    end
    tick();
    dcache_req_valid = 1'b0;
    tick(); tick();
    rst_aL = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (dcache_resp_valid || icache_resp_valid) seen++;
      tick();
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midrst_no_resp got %0d pulses exp 0", seen);
    end
    rst_aL = 1'b1;
    txn(1'b1, 1'b0, 29'h30, 64'h0, w, l, rd, no, nx);
    vectors++;
    if (w !== 0 || l !== LAT || rd !== 64'h1234 || no !== 1) begin
      miscompares++;
      $display("FAIL midrst_after got wait=%0d lat=%0d data=%h pulses=%0d exp 0 %0d 1234 1", w, l, rd, no, LAT);
    end
  endtask

  function automatic logic [28:0] rnd_addr();
    return 29'($urandom_range(0, 7)) + 29'(1024 * $urandom_range(0, 3));
  endfunction

  // Model: a request in flight is described by its response cycle; storage is an
  // array indexed by address modulo depth; ties go to the port not granted last.
  task automatic test_random_contention();
    logic [63:0] mm [int];
    bit pending, p_dc, p_wr, last_was_ic, resp_now;
    int resp_c, p_idx;
    logic [63:0] p_d, exp_data, v;
    bit iv, dv, dt, nv;
    logic [28:0] ia, da, na;
    logic [63:0] dd, nd;
    bit e_ic_rdy, e_dc_rdy, e_ic_rv, e_dc_rv;
    logic [63:0] e_ic_d, e_dc_d;

    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = {$urandom, $urandom};
      preload(29'(i), v);
      mm[i] = v;
    end
    pending = 0; last_was_ic = 1; resp_c = 0; p_dc = 0; p_wr = 0; p_idx = 0; p_d = '0;

    for (int c = 0; c < 240; c++) begin
      iv = (c < 40) ? 1'b1 : 1'($urandom_range(0, 1));
      dv = (c < 40) ? 1'b1 : 1'($urandom_range(0, 1));
      dt = 1'($urandom_range(0, 1));
      ia = rnd_addr(); da = rnd_addr(); dd = {$urandom, $urandom};
      resp_now = pending && (c == resp_c);
      nv = (c >= 40) && ($urandom_range(0, 7) == 0) && !(resp_now && p_wr);
      na = rnd_addr(); nd = {$urandom, $urandom};

      icache_req_valid = iv; icache_req_block_addr = ia;
      dcache_req_valid = dv; dcache_req_type = dt;
      dcache_req_block_addr = da; dcache_req_block_data = dd;
      init_valid = nv; init_block_addr = na; init_block_data = nd;
      #1;

      exp_data = p_wr ? p_d : mm[p_idx];
      e_ic_rv  = resp_now && !p_dc;
      e_dc_rv  = resp_now && p_dc;
      e_ic_d   = e_ic_rv ? exp_data : 64'h0;
      e_dc_d   = e_dc_rv ? exp_data : 64'h0;
      e_dc_rdy = !pending && !nv && dv && (!iv || last_was_ic);
      e_ic_rdy = !pending && !nv && iv && (!dv || !last_was_ic);

      vectors++;
      if (icache_req_ready !== e_ic_rdy) begin
        miscompares++;
        $display("FAIL rand_ic_ready c=%0d got %b exp %b", c, icache_req_ready, e_ic_rdy);
      end
      vectors++;
      if (dcache_req_ready !== e_dc_rdy) begin
        miscompares++;
        $display("FAIL rand_dc_ready c=%0d got %b exp %b", c, dcache_req_ready, e_dc_rdy);
      end
      vectors++;
      if (icache_resp_valid !== e_ic_rv) begin
        miscompares++;
        $display("FAIL rand_ic_resp_valid c=%0d got %b exp %b", c, icache_resp_valid, e_ic_rv);
      end
      vectors++;
      if (dcache_resp_valid !== e_dc_rv) begin
        miscompares++;
        $display("FAIL rand_dc_resp_valid c=%0d got %b exp %b", c, dcache_resp_valid, e_dc_rv);
      end
      vectors++;
      if (icache_resp_block_data !== e_ic_d) begin
        miscompares++;
        $display("FAIL rand_ic_data c=%0d got %h exp %h", c, icache_resp_block_data, e_ic_d);
      end
      vectors++;
      if (dcache_resp_block_data !== e_dc_d) begin
        miscompares++;
        $display("FAIL rand_dc_data c=%0d got %h exp %h", c, dcache_resp_block_data, e_dc_d);
      end

      if (resp_now) begin
        if (p_wr) mm[p_idx] = p_d;
        pending = 0;
      end
      if (nv) mm[int'(na % 29'd1024)] = nd;
      if (e_ic_rdy || e_dc_rdy) begin
        pending = 1;
        resp_c  = c + LAT;
        p_dc    = e_dc_rdy;
        p_wr    = e_dc_rdy && dt;
        p_idx   = int'((e_dc_rdy ? da : ia) % 29'd1024);
        p_d     = dd;
        last_was_ic = e_ic_rdy;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_aL = 1'b0;
    test_reset();
    test_round_robin();
    test_preload_read();
    test_write_read();
    test_alias();
    test_reset_mid_busy();
    test_random_contention();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
